tcp_rx_notify_handler: RTL and testbench
========================================

Name: tcp_rx_notify_handler

Overview:
- Consumes TCP/IP QSFP0 RX notifications and issues read-package requests in chunks of at most MAX_PKG bytes.
- Absorbs the returned RX metadata, then forwards the RX payload stream to the collective engine's RX data input, tagging each beat with its session ID on tdest.
- Sits between the network stack's notify/rd_pkg/rx_meta/RX-data interfaces and the collective engine's eth_rx inputs.

Parameters:
- DATA_W, 512, RX data width in bits.
- MAX_PKG, 4096, largest read request in bytes. Must be a multiple of DATA_W/8 and ≤ 65535.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset. Asynchronous assert, active-low.
- s_notify_valid/ready  in/out  1/1  notification handshake.
- s_notify_data  in  88  [15:0] sid, [31:16] len, [63:32] ip, [79:64] port, [80] closed, [87:81] reserved.
- m_rd_pkg_valid/ready  out/in  1/1  read request handshake.
- m_rd_pkg_data  out  32  [15:0] sid, [31:16] len.
- s_rx_meta_valid/ready  in/out  1/1  RX meta handshake.
- s_rx_meta_data  in  16  sid.
- s_axis_tdata/tkeep/tlast/tvalid  in  DATA_W/DATA_W/8/1/1  RX payload from stack.
- s_axis_tready  out  1  ready for RX payload.
- m_axis_tdata/tkeep/tlast/tvalid  out  DATA_W/DATA_W/8/1/1  RX payload to engine.
- m_axis_tdest  out  16  session ID of the current transfer.
- m_axis_tready  in  1  engine ready.
- closed_cnt  out  32  count of accepted notifications with closed=1.
- len_err  out  1  sticky flag: payload length mismatch.
- sid_err  out  1  sticky flag: RX meta session mismatch.
- busy  out  1  high when state≠IDLE.

Behaviour:
- Reset (async, aresetn=0): state=IDLE; all valid/ready outputs 0; m_rd_pkg_data=0; m_axis_tdest=0; closed_cnt=0; len_err=0; sid_err=0. Reset mid-transfer abandons the transfer; nothing is replayed.
- IDLE:
  - s_notify_ready=1.
  - On handshake with closed=1: closed_cnt+1 (saturates at 2^32-1); stay IDLE.
  - On handshake with closed=0 and len=0: discard; stay IDLE.
  - Otherwise: latch sid and rem=len; go to REQ.
- REQ:
  - Registered output. m_rd_pkg_valid=1 one cycle after notify acceptance.
  - Request length chunk = min(rem, MAX_PKG).
  - valid and data stay stable until ready.
  - On handshake: rem -= chunk; latch chunk; go to META.
- META:
  - s_rx_meta_ready=1.
  - On handshake: if meta sid ≠ latched sid, set sid_err; data still proceeds under the latched sid.
  - Clear byte counter bcnt; go to DATA.
- DATA:
  - Combinational pass-through: m_axis_tvalid = s_axis_tvalid; s_axis_tready = m_axis_tready; tdata/tkeep/tlast forwarded unchanged; m_axis_tdest = latched sid.
  - All stream valid/ready outputs are 0 outside DATA.
  - Each accepted beat: bcnt += popcount(tkeep). bcnt is 17 bits, and tkeep is contiguous from LSB.
  - On the tlast beat: if bcnt (including the last beat) ≠ chunk, set len_err.
  - After tlast: if rem>0 go to REQ (next chunk, same sid), else go to IDLE.
  - A beat where bcnt reaches chunk without tlast sets len_err; the transfer continues until tlast.
- s_notify_ready=0 outside IDLE, so notifications back-pressure upstream. One session is in flight at a time.
- Sticky flags clear only on reset.
- Throughput: one beat per cycle in DATA. Overhead per chunk is at least 2 cycles (REQ and META handshakes). Back-to-back notifications incur 1 IDLE cycle.

Test Plan:
- Notify sid=5 len=128, closed=0 → rd_pkg {sid=5, len=128} one cycle later; meta sid=5; 2 beats, full keep, last on beat 2 → m_axis tdest=5, 2 beats; len_err=0; return to IDLE.
- Notify sid=7 len=10000, MAX_PKG=4096 → rd_pkg lengths 4096, 4096, 1808 in order; each followed by meta and data (64, 64, 29 beats; last beat tkeep=0xFFFF) → no errors; busy drops after the final tlast.
- Notify closed=1 twice, plus one notify with len=0 → no rd_pkg issued; closed_cnt=2.
- m_axis_tready toggled 50% and m_rd_pkg_ready held low 10 cycles → rd_pkg data stable throughout; no beats lost or duplicated; output order preserved.
- Meta sid=9 against latched sid=5, then 1 beat with tlast for a 128-byte chunk → sid_err=1, len_err=1; tdest=5.
- aresetn asserted mid-DATA → outputs go to reset values immediately. After release, a new notify is accepted and handled normally.

Source files
------------

// File: rtl/tcp_rx_notify_handler.sv
// Turns network-stack RX notifications into chunked read-package requests and
// forwards each chunk's payload to the collective engine, tagged with its session ID.
module tcp_rx_notify_handler #(
  parameter int DATA_W  = 512,
  parameter int MAX_PKG = 4096
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_notify_valid,
  output logic                  s_notify_ready,
  input  logic [87:0]           s_notify_data,
  output logic                  m_rd_pkg_valid,
  input  logic                  m_rd_pkg_ready,
  output logic [31:0]           m_rd_pkg_data,
  input  logic                  s_rx_meta_valid,
  output logic                  s_rx_meta_ready,
  input  logic [15:0]           s_rx_meta_data,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  output logic [15:0]           m_axis_tdest,
  input  logic                  m_axis_tready,
  output logic [31:0]           closed_cnt,
  output logic                  len_err,
  output logic                  sid_err,
  output logic                  busy
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int POP_W  = $clog2(KEEP_W + 1);
  localparam logic [15:0] MAX_LEN = 16'(MAX_PKG);

  typedef enum logic [1:0] {IDLE, REQ, META, DATA} state_t;

  state_t      state_q, state_d;
  logic [15:0] sid_q, sid_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] chunk_q, chunk_d;
  logic [16:0] bcnt_q, bcnt_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] closed_cnt_q, closed_cnt_d;
  logic        len_err_q, len_err_d;
  logic        sid_err_q, sid_err_d;
  logic        notify_ready_q, notify_ready_d;

  logic [15:0] n_sid, n_len;
  logic        n_closed;
  logic        unused_notify;
  logic [POP_W-1:0] pop;
  logic [16:0] bcnt_sum;
  logic        beat;

  assign n_sid    = s_notify_data[15:0];
  assign n_len    = s_notify_data[31:16];
  assign n_closed = s_notify_data[80];
  assign unused_notify = ^{s_notify_data[87:81], s_notify_data[79:32]};

  function automatic logic [15:0] clip(input logic [15:0] r);
    return (r > MAX_LEN) ? MAX_LEN : r;
  endfunction

  // tkeep is contiguous, but a plain popcount is just as cheap and needs no such assumption
  always_comb begin
    pop = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      pop = pop + POP_W'(s_axis_tkeep[i]);
    end
  end

  assign beat     = (state_q == DATA) && s_axis_tvalid && m_axis_tready;
  assign bcnt_sum = bcnt_q + 17'(pop);

  always_comb begin
    state_d        = state_q;
    sid_d          = sid_q;
    rem_d          = rem_q;
    chunk_d        = chunk_q;
    bcnt_d         = bcnt_q;
    rd_valid_d     = rd_valid_q;
    rd_data_d      = rd_data_q;
    closed_cnt_d   = closed_cnt_q;
    len_err_d      = len_err_q;
    sid_err_d      = sid_err_q;
    case (state_q)
      IDLE: begin
        if (s_notify_valid && notify_ready_q) begin
          if (n_closed) begin
            if (closed_cnt_q != 32'hFFFF_FFFF) closed_cnt_d = closed_cnt_q + 32'd1;
          end else if (n_len != 16'd0) begin
            sid_d      = n_sid;
            rem_d      = n_len;
            rd_valid_d = 1'b1;
            rd_data_d  = {clip(n_len), n_sid};
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        if (rd_valid_q && m_rd_pkg_ready) begin
          rem_d      = rem_q - rd_data_q[31:16];
          chunk_d    = rd_data_q[31:16];
          rd_valid_d = 1'b0;
          state_d    = META;
        end
      end
      META: begin
        if (s_rx_meta_valid) begin
          if (s_rx_meta_data != sid_q) sid_err_d = 1'b1;
          bcnt_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          bcnt_d = bcnt_sum;
          if (s_axis_tlast) begin
            if (bcnt_sum != {1'b0, chunk_q}) len_err_d = 1'b1;
            if (rem_q != 16'd0) begin
              rd_valid_d = 1'b1;
              rd_data_d  = {clip(rem_q), sid_q};
              state_d    = REQ;
            end else begin
              state_d = IDLE;
            end
          end else if (bcnt_sum >= {1'b0, chunk_q}) begin
            // chunk already full but the stack keeps sending; flag it and drain to tlast
            len_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    notify_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= IDLE;
      sid_q          <= '0;
      rem_q          <= '0;
      chunk_q        <= '0;
      bcnt_q         <= '0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      closed_cnt_q   <= '0;
      len_err_q      <= 1'b0;
      sid_err_q      <= 1'b0;
      notify_ready_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sid_q          <= sid_d;
      rem_q          <= rem_d;
      chunk_q        <= chunk_d;
      bcnt_q         <= bcnt_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
      closed_cnt_q   <= closed_cnt_d;
      len_err_q      <= len_err_d;
      sid_err_q      <= sid_err_d;
      notify_ready_q <= notify_ready_d;
    end
  end

  assign s_notify_ready  = notify_ready_q;
  assign m_rd_pkg_valid  = rd_valid_q;
  assign m_rd_pkg_data   = rd_data_q;
  assign s_rx_meta_ready = (state_q == META);
  assign s_axis_tready   = (state_q == DATA) && m_axis_tready;
  assign m_axis_tvalid   = (state_q == DATA) && s_axis_tvalid;
  assign m_axis_tdata    = s_axis_tdata;
  assign m_axis_tkeep    = s_axis_tkeep;
  assign m_axis_tlast    = s_axis_tlast;
  assign m_axis_tdest    = sid_q;
  assign closed_cnt      = closed_cnt_q;
  assign len_err         = len_err_q;
  assign sid_err         = sid_err_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_tcp_rx_notify_handler.sv
// Bench for tcp_rx_notify_handler: directed vector table, reset-in-flight sequence,
// then randomized sessions against a chunking/flag model.
module tb_tcp_rx_notify_handler;
  localparam int DATA_W  = 512;
  localparam int KEEP_W  = DATA_W / 8;
  localparam int MAX_PKG = 4096;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic s_notify_valid = 1'b0;
  logic s_notify_ready;
  logic [87:0] s_notify_data = '0;
  logic m_rd_pkg_valid;
  logic m_rd_pkg_ready = 1'b0;
  logic [31:0] m_rd_pkg_data;
  logic s_rx_meta_valid = 1'b0;
  logic s_rx_meta_ready;
  logic [15:0] s_rx_meta_data = '0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic [KEEP_W-1:0] s_axis_tkeep = '0;
  logic s_axis_tlast = 1'b0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic m_axis_tlast;
  logic m_axis_tvalid;
  logic [15:0] m_axis_tdest;
  logic m_axis_tready = 1'b0;
  logic [31:0] closed_cnt;
  logic len_err;
  logic sid_err;
  logic busy;

  always #5 aclk = ~aclk;

  tcp_rx_notify_handler #(.DATA_W(DATA_W), .MAX_PKG(MAX_PKG)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_notify_valid(s_notify_valid), .s_notify_ready(s_notify_ready), .s_notify_data(s_notify_data),
    .m_rd_pkg_valid(m_rd_pkg_valid), .m_rd_pkg_ready(m_rd_pkg_ready), .m_rd_pkg_data(m_rd_pkg_data),
    .s_rx_meta_valid(s_rx_meta_valid), .s_rx_meta_ready(s_rx_meta_ready), .s_rx_meta_data(s_rx_meta_data),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdest(m_axis_tdest), .m_axis_tready(m_axis_tready),
    .closed_cnt(closed_cnt), .len_err(len_err), .sid_err(sid_err), .busy(busy)
  );

  typedef struct {
    logic [15:0] sid;
    logic [15:0] len;
    bit          closed;
    logic [15:0] msid;
    int          delta;
    bit          rr;
    int          hold;
    int          c0, c1, c2;
    int          cc;
    bit          le, se;
  } vec_t;

  int total = 0;
  int bad = 0;
  int exp_chunks[$];
  int unsigned closed_exp;
  bit len_err_exp, sid_err_exp;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic notify_hs(input logic [15:0] sid, input logic [15:0] len, input bit closed);
    int cyc = 0;
    s_notify_data  = {7'd0, closed, 16'($urandom), 32'($urandom), len, sid};
    s_notify_valid = 1'b1;
    #1;
    while (!s_notify_ready && cyc < 50) begin
      @(negedge aclk); #1; cyc++;
    end
    chk("notify_timeout", cyc < 50, 1);
    @(negedge aclk);
    s_notify_valid = 1'b0;
  endtask

  task automatic rdpkg_hs(input logic [15:0] sid, input int c, input int hold);
    chk("rdpkg_data", m_rd_pkg_data, {16'(c), sid});
    for (int h = 0; h < hold; h++) begin
      @(negedge aclk);
      chk("rdpkg_hold_valid", m_rd_pkg_valid, 1);
      chk("rdpkg_hold_data", m_rd_pkg_data, {16'(c), sid});
    end
    m_rd_pkg_ready = 1'b1;
    @(negedge aclk);
    m_rd_pkg_ready = 1'b0;
    chk("rdpkg_drop", m_rd_pkg_valid, 0);
  endtask

  task automatic meta_hs(input logic [15:0] msid);
    int cyc = 0;
    s_rx_meta_data  = msid;
    s_rx_meta_valid = 1'b1;
    #1;
    while (!s_rx_meta_ready && cyc < 50) begin
      @(negedge aclk); #1; cyc++;
    end
    chk("meta_timeout", cyc < 50, 1);
    @(negedge aclk);
    s_rx_meta_valid = 1'b0;
  endtask

  task automatic stream_chunk(input logic [15:0] sid, input int bytes, input bit rr);
    logic [511:0] d[$];
    logic [63:0]  k[$];
    int r = bytes;
    int i = 0;
    int cyc = 0;
    while (r > 0) begin
      logic [511:0] w;
      for (int j = 0; j < 16; j++) w[j*32 +: 32] = $urandom;
      d.push_back(w);
      k.push_back(r >= 64 ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << r) - 64'd1);
      r -= 64;
    end
    while (i < d.size() && cyc < 2000) begin
      s_axis_tvalid = rr ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_axis_tdata  = d[i];
      s_axis_tkeep  = k[i];
      s_axis_tlast  = (i == d.size() - 1);
      m_axis_tready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("m_tvalid", m_axis_tvalid, s_axis_tvalid);
      chk("s_tready", s_axis_tready, m_axis_tready);
      if (s_axis_tvalid && m_axis_tready) begin
        chk("tdata", m_axis_tdata, d[i]);
        chk("tkeep", m_axis_tkeep, k[i]);
        chk("tlast", m_axis_tlast, i == d.size() - 1);
        chk("tdest", m_axis_tdest, sid);
        i++;
      end
      @(negedge aclk);
      cyc++;
    end
    chk("stream_timeout", i, d.size());
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
  endtask

  // Full session driven from exp_chunks; mism reports whether any chunk was sent with a wrong size.
  task automatic run_session(input logic [15:0] sid, input logic [15:0] len, input bit closed,
                             input logic [15:0] msid, input int delta, input bit rr,
                             input int hold, output bit mism);
    mism = 1'b0;
    notify_hs(sid, len, closed);
    if (exp_chunks.size() == 0) begin
      chk("no_rdpkg", m_rd_pkg_valid, 0);
      chk("idle_busy", busy, 0);
    end else begin
      foreach (exp_chunks[n]) begin
        int bytes;
        chk("rdpkg_latency", m_rd_pkg_valid, 1);
        chk("busy_high", busy, 1);
        rdpkg_hs(sid, exp_chunks[n], hold);
        meta_hs(msid);
        bytes = exp_chunks[n] + delta;
        if (bytes < 1) bytes = 1;
        if (bytes != exp_chunks[n]) mism = 1'b1;
        stream_chunk(sid, bytes, rr);
      end
      chk("busy_after", busy, 0);
    end
  endtask

  function automatic void plan(input int len);
    int rem = len;
    exp_chunks.delete();
    while (rem > 0) begin
      int c = (rem > MAX_PKG) ? MAX_PKG : rem;
      exp_chunks.push_back(c);
      rem -= c;
    end
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    bit mism;
    tbl[0] = '{16'd5,      16'd128,   1'b0, 16'd5,      0,   1'b0, 0,  128,  0,    0,    0, 1'b0, 1'b0};
    tbl[1] = '{16'd7,      16'd10000, 1'b0, 16'd7,      0,   1'b0, 0,  4096, 4096, 1808, 0, 1'b0, 1'b0};
    tbl[2] = '{16'd1,      16'd50,    1'b1, 16'd1,      0,   1'b0, 0,  0,    0,    0,    1, 1'b0, 1'b0};
    tbl[3] = '{16'd2,      16'd0,     1'b1, 16'd2,      0,   1'b0, 0,  0,    0,    0,    2, 1'b0, 1'b0};
    tbl[4] = '{16'd3,      16'd0,     1'b0, 16'd3,      0,   1'b0, 0,  0,    0,    0,    2, 1'b0, 1'b0};
    tbl[5] = '{16'h1234,   16'd700,   1'b0, 16'h1234,   0,   1'b1, 10, 700,  0,    0,    2, 1'b0, 1'b0};
    tbl[6] = '{16'd5,      16'd128,   1'b0, 16'd9,      -64, 1'b0, 0,  128,  0,    0,    2, 1'b1, 1'b1};

    // reset state
    @(negedge aclk);
    chk("rst_notify_ready", s_notify_ready, 0);
    chk("rst_rdpkg_valid", m_rd_pkg_valid, 0);
    chk("rst_rdpkg_data", m_rd_pkg_data, 0);
    chk("rst_meta_ready", s_rx_meta_ready, 0);
    chk("rst_tdest", m_axis_tdest, 0);
    chk("rst_closed_cnt", closed_cnt, 0);
    chk("rst_busy", busy, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    foreach (tbl[v]) begin
      exp_chunks.delete();
      if (tbl[v].c0 != 0) exp_chunks.push_back(tbl[v].c0);
      if (tbl[v].c1 != 0) exp_chunks.push_back(tbl[v].c1);
      if (tbl[v].c2 != 0) exp_chunks.push_back(tbl[v].c2);
      run_session(tbl[v].sid, tbl[v].len, tbl[v].closed, tbl[v].msid, tbl[v].delta,
                  tbl[v].rr, tbl[v].hold, mism);
      chk("vec_closed_cnt", closed_cnt, tbl[v].cc);
      chk("vec_len_err", len_err, tbl[v].le);
      chk("vec_sid_err", sid_err, tbl[v].se);
      $display("vector %0d sid=%0d len=%0d closed=%0d -> closed_cnt=%0d len_err=%0d sid_err=%0d",
               v, tbl[v].sid, tbl[v].len, tbl[v].closed, closed_cnt, len_err, sid_err);
    end

    // reset while a chunk is streaming
    notify_hs(16'd3, 16'd256, 1'b0);
    rdpkg_hs(16'd3, 256, 0);
    meta_hs(16'd3);
    s_axis_tvalid = 1'b1;
    s_axis_tkeep  = '1;
    s_axis_tdata  = {16{32'hA5A5_0003}};
    m_axis_tready = 1'b1;
    #1;
    chk("pre_reset_tvalid", m_axis_tvalid, 1);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_tready", s_axis_tready, 0);
    chk("mid_rst_notify_ready", s_notify_ready, 0);
    chk("mid_rst_rdpkg_valid", m_rd_pkg_valid, 0);
    chk("mid_rst_rdpkg_data", m_rd_pkg_data, 0);
    chk("mid_rst_meta_ready", s_rx_meta_ready, 0);
    chk("mid_rst_tdest", m_axis_tdest, 0);
    chk("mid_rst_closed_cnt", closed_cnt, 0);
    chk("mid_rst_len_err", len_err, 0);
    chk("mid_rst_sid_err", sid_err, 0);
    chk("mid_rst_busy", busy, 0);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    $display("reset mid-DATA: outputs returned to reset values");

    closed_exp = 0;
    len_err_exp = 1'b0;
    sid_err_exp = 1'b0;
    plan(192);
    run_session(16'h42, 16'd192, 1'b0, 16'h42, 0, 1'b0, 0, mism);
    chk("post_rst_len_err", len_err, 0);
    chk("post_rst_sid_err", sid_err, 0);
    chk("post_rst_closed_cnt", closed_cnt, 0);
    $display("post-reset session sid=66 len=192 done");

    for (int s = 0; s < 25; s++) begin
      logic [15:0] sid, len, msid;
      bit closed, rr;
      int delta, hold;
      sid    = 16'($urandom);
      closed = ($urandom_range(0, 9) == 0);
      len    = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(1, 300)) : 16'($urandom_range(1, 9000));
      msid   = ($urandom_range(0, 6) == 0) ? sid ^ 16'($urandom_range(1, 65535)) : sid;
      delta  = 0;
      if ($urandom_range(0, 6) == 0)
        delta = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 70)) : -int'($urandom_range(1, 70));
      rr   = 1'b1;
      hold = $urandom_range(0, 3);
      if (closed) begin
        exp_chunks.delete();
        if (closed_exp != 32'hFFFF_FFFF) closed_exp++;
      end else begin
        plan(int'(len));
        if (msid != sid) sid_err_exp = 1'b1;
      end
      run_session(sid, len, closed, msid, delta, rr, hold, mism);
      if (mism) len_err_exp = 1'b1;
      chk("rnd_closed_cnt", closed_cnt, closed_exp);
      chk("rnd_len_err", len_err, len_err_exp);
      chk("rnd_sid_err", sid_err, sid_err_exp);
      $display("random %0d sid=%0h len=%0d closed=%0d chunks=%0d delta=%0d -> len_err=%0d sid_err=%0d",
               s, sid, len, closed, exp_chunks.size(), delta, len_err, sid_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
